// File: rtl/sram_responder.sv
// Synthesizable stand-in for the external 1Mx16 async SRAM: active-low bus, pipelined reads,
// byte-lane writes, full re-init after reset. Define SRAM_RESP_PRELOAD_EN to load the boot pattern.
module sram_responder #(
    parameter int ADDR_W     = 10,
    parameter int READ_LAT   = 1,
    parameter int INIT_WORDS = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        CE,
    input  logic        UB,
    input  logic        LB,
    input  logic        OE,
    input  logic        WE,
    input  logic [19:0] ADDR,
    inout  wire  [15:0] Data,
    output logic        Ready,
    output logic        Err,
    output logic [15:0] Wr_count,
    output logic        state_dbg
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        S_INIT  = 1'b0,
        S_SERVE = 1'b1
    } state_t;

    state_t state_q;
    state_t state_d;

    logic              init_active;
    logic [ADDR_W-1:0] init_idx;
    logic [15:0]       init_word;

    logic [15:0]       mem [DEPTH];
    logic [ADDR_W-1:0] mem_addr;
    logic [15:0]       mem_wdata;
    logic              we_hi;
    logic              we_lo;

    logic              in_range;
    logic              wr_req;
    logic              rd_req;
    logic              bus_access;
    logic [15:0]       rd_word;
    logic [15:0]       push_word;
    logic [15:0]       pipe [READ_LAT];
    logic [15:0]       pipe_out;

    // Valid/ready-style contract on the bus: a request is only honoured while Ready=1;
    // during INIT every bus input is ignored and Data stays released.

    // ---------------- FSM: state register ----------------
    always_ff @(posedge Clk) begin
        if (!Reset) state_q <= S_INIT;
        else        state_q <= state_d;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_INIT:  if (&init_idx) state_d = S_SERVE;
            S_SERVE: state_d = S_SERVE;
            default: state_d = S_INIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        Ready       = (state_q == S_SERVE);
        init_active = (state_q == S_INIT);
        state_dbg   = (state_q == S_SERVE);
    end

    always_ff @(posedge Clk) begin
        if (!Reset)           init_idx <= '0;
        else if (init_active) init_idx <= init_idx + 1'b1;
    end

`ifdef SRAM_RESP_PRELOAD_EN
    logic [31:0] idx_ext;
    always_comb begin
        idx_ext   = 32'(init_idx);
        init_word = (idx_ext < 32'(INIT_WORDS)) ? {8'hA5, idx_ext[7:0]} : 16'h0000;
    end
`else
    always_comb init_word = 16'h0000;
`endif

    // ---------------- bus decode ----------------
    always_comb begin
        in_range   = (ADDR[19:ADDR_W] == '0);
        wr_req     = Ready && !CE && !WE;
        rd_req     = Ready && !CE && WE && !OE;
        bus_access = Ready && !CE && (!WE || !OE);
    end

    // Init and bus writes share one write port; init owns it until SERVE.
    always_comb begin
        mem_addr  = init_active ? init_idx : ADDR[ADDR_W-1:0];
        mem_wdata = init_active ? init_word : Data;
        we_hi     = init_active || (wr_req && in_range && !UB);
        we_lo     = init_active || (wr_req && in_range && !LB);
    end

    always_ff @(posedge Clk) begin
        if (we_hi) mem[mem_addr][15:8] <= mem_wdata[15:8];
        if (we_lo) mem[mem_addr][7:0]  <= mem_wdata[7:0];
    end

    // Combinational array read so a write is visible to a read sampled one edge later.
    always_comb begin
        rd_word   = mem[ADDR[ADDR_W-1:0]];
        push_word = (rd_req && in_range) ? rd_word : 16'h0000;
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            for (int i = 0; i < READ_LAT; i++) pipe[i] <= 16'h0000;
        end else begin
            pipe[0] <= push_word;
            for (int i = 1; i < READ_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end

    assign pipe_out = pipe[READ_LAT-1];

    always_ff @(posedge Clk) begin
        if (!Reset)                      Err <= 1'b0;
        else if (bus_access && !in_range) Err <= 1'b1;
    end

    always_ff @(posedge Clk) begin
        if (!Reset)
            Wr_count <= 16'h0000;
        else if (wr_req && in_range && (!UB || !LB) && (Wr_count != 16'hFFFF))
            Wr_count <= Wr_count + 16'h0001;
    end

    assign Data[15:8] = (rd_req && !UB) ? pipe_out[15:8] : 8'bzzzz_zzzz;
    assign Data[7:0]  = (rd_req && !LB) ? pipe_out[7:0]  : 8'bzzzz_zzzz;

endmodule
